config_stream_loader: RTL

- Upstream configuration stage for the fabric tile: receives a byte-serial configuration stream and produces the 33-bit logic tile memory and the 4x4 switch box configure word.
- Replaces the bench-side memory-file preload with a real load path.
- Frames are sync-prefixed and XOR-checksummed, staged in a shadow register, and committed atomically only on a good checksum.

---
 rtl/config_stream_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/config_stream_loader.sv
// config_stream_loader
//
// Upstream configuration stage for the fabric tile. Receives a byte-serial,
// sync-prefixed, XOR-checksummed configuration frame and produces the logic
// tile memory word and the switch box configure word. Payload bytes are
// staged in a shadow register and committed atomically only when the trailing
// checksum byte matches, so downstream never sees a partial configuration.
//
// Frame: SYNC_BYTE, NBYTES payload bytes (LSB byte first), XOR of payload.
// Payload layout: [LT_BITS-1:0] lt_mem, [LT_BITS+SB_BITS-1:LT_BITS]
// sb_configure, remaining high bits of the last byte are pad.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   data_in      in   stream byte
//   data_valid   in   data_in valid this cycle
//   data_ready   out  loader accepts a byte this cycle (low during commit)
//   lt_mem       out  committed logic tile configuration
//   sb_configure out  committed switch box configuration
//   cfg_valid    out  high once any frame has been committed
//   cfg_done     out  one-cycle pulse on commit
//   cfg_error    out  sticky checksum-failure flag, cleared by a good commit

`timescale 1ns/1ps

module config_stream_loader #(
    parameter int          LT_BITS   = 33,
    parameter int          SB_BITS   = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         data_in,
    input  logic               data_valid,
    output logic               data_ready,
    output logic [LT_BITS-1:0] lt_mem,
    output logic [SB_BITS-1:0] sb_configure,
    output logic               cfg_valid,
    output logic               cfg_done,
    output logic               cfg_error
);

    localparam int P      = LT_BITS + SB_BITS;
    localparam int NBYTES = (P + 7) / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        COMMIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       csum;
    logic [P-1:0]     shadow;

    logic accept;
    logic ready_state;
    logic start_frame;
    logic load_byte;
    logic set_error;
    logic do_commit;

    // Ready is forced low while reset is held so nothing is consumed then.
    assign data_ready = ready_state && !reset;
    assign accept     = data_valid && data_ready;

    always_comb begin
        state_next  = state;
        ready_state = 1'b1;
        start_frame = 1'b0;
        load_byte   = 1'b0;
        set_error   = 1'b0;
        do_commit   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (data_in == SYNC_BYTE)) begin
                    start_frame = 1'b1;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                // A sync-valued byte here is payload, not a restart.
                if (accept) begin
                    load_byte = 1'b1;
                    if (byte_cnt == CNT_W'(NBYTES - 1)) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (data_in == csum) begin
                        state_next = COMMIT;
                    end else begin
                        set_error  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            COMMIT: begin
                ready_state = 1'b0;
                do_commit   = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            csum         <= '0;
            shadow       <= '0;
            lt_mem       <= '0;
            sb_configure <= '0;
            cfg_valid    <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
        end else begin
            state    <= state_next;
            cfg_done <= do_commit;

            if (start_frame) begin
                byte_cnt <= '0;
                csum     <= '0;
            end

            if (load_byte) begin
                // Per-bit write keeps the shadow exactly P bits wide; pad bits
                // of the final byte simply have no destination.
                for (int j = 0; j < P; j++) begin
                    if (byte_cnt == CNT_W'(j / 8)) begin
                        shadow[j] <= data_in[j % 8];
                    end
                end
                csum     <= csum ^ data_in;
                byte_cnt <= byte_cnt + CNT_W'(1);
            end

            if (set_error) begin
                cfg_error <= 1'b1;
            end

            if (do_commit) begin
                lt_mem       <= shadow[LT_BITS-1:0];
                sb_configure <= shadow[P-1:LT_BITS];
                cfg_valid    <= 1'b1;
                cfg_error    <= 1'b0;
            end
        end
    end

endmodule
